// File: rtl/trn_tx_ep_arb.sv
// Round-robin arbiter that shares one PCIe TRN tx interface among NREQ requester engines.
// Optional grant watchdog is enabled by defining EP_ARB_WDOG_EN.
`timescale 1ns/1ps

module trn_tx_ep_arb #(
    parameter int NREQ     = 3,
    parameter int IDW      = 2,
    parameter int WDOG_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_ep,
    input  logic [NREQ-1:0]      drv_ep,
    output logic [NREQ-1:0]      my_trn,
    input  logic [64*NREQ-1:0]   req_td,
    input  logic [8*NREQ-1:0]    req_trem_n,
    input  logic [NREQ-1:0]      req_tsof_n,
    input  logic [NREQ-1:0]      req_teof_n,
    input  logic [NREQ-1:0]      req_tsrc_rdy_n,
    output logic [NREQ-1:0]      req_tdst_rdy_n,
    output logic [63:0]          trn_td,
    output logic [7:0]           trn_trem_n,
    output logic                 trn_tsof_n,
    output logic                 trn_teof_n,
    output logic                 trn_tsrc_rdy_n,
    input  logic                 trn_tdst_rdy_n,
    output logic [IDW-1:0]       grant_id,
    output logic [1:0]           arb_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_BUSY,
        S_RELEASE
    } state_t;

`ifdef EP_ARB_WDOG_EN
    localparam bit WDOG_ON = 1'b1;
`else
    localparam bit WDOG_ON = 1'b0;
`endif

    localparam int WDW = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   pick_idx;
    logic             pick_vld;
    logic             in_pkt;
    logic             mux_on;
    logic             beat_acc;
    logic             drv_w;
    logic             req_w;
    logic             drop_err;
    logic             wdog_trip;
    logic             wdog_fire;
    logic [WDW-1:0]   wdog_cnt;

    assign drv_w     = drv_ep[grant_id];
    assign req_w     = req_ep[grant_id];
    assign mux_on    = (state == S_GRANT) || (state == S_BUSY);
    assign beat_acc  = mux_on && !trn_tsrc_rdy_n && !trn_tdst_rdy_n;
    assign wdog_fire = WDOG_ON && (wdog_cnt == WDW'(WDOG_CYC - 1));

    // Descending scan so the requester closest to rr_ptr (smallest offset) is written last and wins.
    always_comb begin
        int idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (req_ep[IDW'(idx)]) begin
                pick_vld = 1'b1;
                pick_idx = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        drop_err  = 1'b0;
        wdog_trip = 1'b0;
        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (drv_w) begin
                    state_nxt = S_BUSY;
                end else if (!req_w) begin
                    state_nxt = S_RELEASE;
                end else if (wdog_fire) begin
                    state_nxt = S_RELEASE;
                    wdog_trip = 1'b1;
                end
            end
            S_BUSY: begin
                if (!drv_w) begin
                    state_nxt = S_RELEASE;
                    drop_err  = in_pkt;
                end
            end
            S_RELEASE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            my_trn   <= '0;
            grant_id <= '0;
            rr_ptr   <= '0;
            arb_err  <= '0;
            in_pkt   <= 1'b0;
            wdog_cnt <= '0;
        end else begin
            state <= state_nxt;

            if ((state == S_IDLE) && pick_vld) begin
                my_trn   <= NREQ'(1) << pick_idx;
                grant_id <= pick_idx;
            end
            // Grant drops in the same update that enters RELEASE.
            if (state_nxt == S_RELEASE) begin
                my_trn <= '0;
            end

            if (state == S_RELEASE) begin
                rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
            end

            if (drop_err) begin
                arb_err[0] <= 1'b1;
                in_pkt     <= 1'b0;
            end else if (beat_acc) begin
                if (!trn_teof_n) begin
                    in_pkt <= 1'b0;
                end else if (!trn_tsof_n) begin
                    in_pkt <= 1'b1;
                end
            end

            if (wdog_trip) begin
                arb_err[1] <= 1'b1;
            end

            if (WDOG_ON && (state == S_GRANT) && (state_nxt == S_GRANT)) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end else begin
                wdog_cnt <= '0;
            end
        end
    end

    // Only the granted requester sees the endpoint; everyone else reads an idle, not-ready bus.
    always_comb begin
        trn_td         = '0;
        trn_trem_n     = 8'hFF;
        trn_tsof_n     = 1'b1;
        trn_teof_n     = 1'b1;
        trn_tsrc_rdy_n = 1'b1;
        req_tdst_rdy_n = '1;
        if (mux_on) begin
            trn_td                   = req_td[64*grant_id +: 64];
            trn_trem_n               = req_trem_n[8*grant_id +: 8];
            trn_tsof_n               = req_tsof_n[grant_id];
            trn_teof_n               = req_teof_n[grant_id];
            trn_tsrc_rdy_n           = req_tsrc_rdy_n[grant_id];
            req_tdst_rdy_n[grant_id] = trn_tdst_rdy_n;
        end
    end

endmodule

// File: tb/tb_trn_tx_ep_arb.sv
// Directed bench for trn_tx_ep_arb: grant latency, round-robin order, error flags, stall and reset.
// Watchdog expectations follow EP_ARB_WDOG_EN.
`timescale 1ns/1ps

module tb_trn_tx_ep_arb;

    logic          clk;
    logic          rst;
    logic [2:0]    req_ep;
    logic [2:0]    drv_ep;
    logic [2:0]    my_trn;
    logic [191:0]  req_td;
    logic [23:0]   req_trem_n;
    logic [2:0]    req_tsof_n;
    logic [2:0]    req_teof_n;
    logic [2:0]    req_tsrc_rdy_n;
    logic [2:0]    req_tdst_rdy_n;
    logic [63:0]   trn_td;
    logic [7:0]    trn_trem_n;
    logic          trn_tsof_n;
    logic          trn_teof_n;
    logic          trn_tsrc_rdy_n;
    logic          trn_tdst_rdy_n;
    logic [1:0]    grant_id;
    logic [1:0]    arb_err;

    int errors = 0;
    int checks = 0;

    trn_tx_ep_arb #(
        .NREQ     (3),
        .IDW      (2),
        .WDOG_CYC (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_ep         (req_ep),
        .drv_ep         (drv_ep),
        .my_trn         (my_trn),
        .req_td         (req_td),
        .req_trem_n     (req_trem_n),
        .req_tsof_n     (req_tsof_n),
        .req_teof_n     (req_teof_n),
        .req_tsrc_rdy_n (req_tsrc_rdy_n),
        .req_tdst_rdy_n (req_tdst_rdy_n),
        .trn_td         (trn_td),
        .trn_trem_n     (trn_trem_n),
        .trn_tsof_n     (trn_tsof_n),
        .trn_teof_n     (trn_teof_n),
        .trn_tsrc_rdy_n (trn_tsrc_rdy_n),
        .trn_tdst_rdy_n (trn_tdst_rdy_n),
        .grant_id       (grant_id),
        .arb_err        (arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int idx, input logic [63:0] td, input logic sof_n,
                                 input logic eof_n, input logic src_rdy_n);
        req_td[64*idx +: 64]  = td;
        req_trem_n[8*idx +: 8] = 8'h00;
        req_tsof_n[idx]       = sof_n;
        req_teof_n[idx]       = eof_n;
        req_tsrc_rdy_n[idx]   = src_rdy_n;
    endtask

    task automatic idleReq(input int idx);
        req_td[64*idx +: 64]   = '0;
        req_trem_n[8*idx +: 8] = 8'hFF;
        req_tsof_n[idx]        = 1'b1;
        req_teof_n[idx]        = 1'b1;
        req_tsrc_rdy_n[idx]    = 1'b1;
    endtask

    // Serves one single-beat TLP from the holder, ending in the IDLE cycle after release.
    task automatic serveOne(input int id);
        logic [2:0]  onehot;
        logic [63:0] data;
        onehot = 3'b001 << id;
        data   = 64'hA5A5_0000_0000_0000 | 64'(id);
        checkOutput($sformatf("rr_grant_%0d", id), {61'd0, my_trn}, {61'd0, onehot});
        checkOutput($sformatf("rr_gid_%0d", id), {62'd0, grant_id}, 64'(id));
        drv_ep = onehot;
        tick();
        applyStimulus(id, data, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput($sformatf("rr_td_%0d", id), trn_td, data);
        tick();
        idleReq(id);
        drv_ep = 3'b000;
        tick();
        checkOutput($sformatf("rr_gap1_%0d", id), {61'd0, my_trn}, 64'd0);
        tick();
        checkOutput($sformatf("rr_gap2_%0d", id), {61'd0, my_trn}, 64'd0);
    endtask

    initial begin
        rst            = 1'b1;
        req_ep         = 3'b000;
        drv_ep         = 3'b000;
        trn_tdst_rdy_n = 1'b0;
        for (int i = 0; i < 3; i++) idleReq(i);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        checkOutput("rst_my_trn", {61'd0, my_trn}, 64'd0);
        checkOutput("rst_grant_id", {62'd0, grant_id}, 64'd0);
        checkOutput("rst_arb_err", {62'd0, arb_err}, 64'd0);
        checkOutput("rst_src_rdy", {63'd0, trn_tsrc_rdy_n}, 64'd1);
        checkOutput("rst_trem", {56'd0, trn_trem_n}, 64'hFF);
        checkOutput("rst_dst_rdy", {61'd0, req_tdst_rdy_n}, 64'h7);

        // Single requester, 3-beat TLP, requester 1 noise must be masked
        req_ep = 3'b001;
        tick();
        checkOutput("t1_grant", {61'd0, my_trn}, 64'h1);
        checkOutput("t1_gid", {62'd0, grant_id}, 64'd0);
        applyStimulus(1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("t1_mask_src", {63'd0, trn_tsrc_rdy_n}, 64'd1);
        drv_ep = 3'b001;
        tick();
        applyStimulus(0, 64'h1111_2222_3333_4444, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("t1_b0_td", trn_td, 64'h1111_2222_3333_4444);
        checkOutput("t1_b0_sof", {63'd0, trn_tsof_n}, 64'd0);
        checkOutput("t1_b0_trem", {56'd0, trn_trem_n}, 64'h00);
        checkOutput("t1_b0_dst", {61'd0, req_tdst_rdy_n}, 64'h6);
        tick();
        applyStimulus(0, 64'h5555_6666_7777_8888, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("t1_b1_td", trn_td, 64'h5555_6666_7777_8888);
        tick();
        applyStimulus(0, 64'h9999_AAAA_BBBB_CCCC, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("t1_b2_td", trn_td, 64'h9999_AAAA_BBBB_CCCC);
        checkOutput("t1_b2_eof", {63'd0, trn_teof_n}, 64'd0);
        tick();
        idleReq(0);
        idleReq(1);
        drv_ep = 3'b000;
        req_ep = 3'b000;
        tick();
        checkOutput("t1_release", {61'd0, my_trn}, 64'd0);
        checkOutput("t1_no_err", {62'd0, arb_err}, 64'd0);
        tick();

        // Round-robin order 0,1,2,0 from a fresh pointer
        rst = 1'b1;
        tick();
        rst    = 1'b0;
        req_ep = 3'b111;
        tick();
        serveOne(0);
        tick();
        serveOne(1);
        tick();
        serveOne(2);
        tick();
        serveOne(0);
        req_ep = 3'b000;
        tick();
        checkOutput("t2_idle", {61'd0, my_trn}, 64'd0);

        // Requester 1 drops drv_ep mid-packet
        req_ep = 3'b010;
        tick();
        checkOutput("t3_grant", {61'd0, my_trn}, 64'h2);
        drv_ep = 3'b010;
        tick();
        applyStimulus(1, 64'hDEAD_BEEF_0000_0001, 1'b0, 1'b1, 1'b0);
        tick();
        idleReq(1);
        drv_ep = 3'b000;
        req_ep = 3'b101;
        tick();
        checkOutput("t3_release", {61'd0, my_trn}, 64'd0);
        checkOutput("t3_err", {62'd0, arb_err}, 64'h1);
        tick();
        tick();
        checkOutput("t3_next_is_2", {61'd0, my_trn}, 64'h4);
        checkOutput("t3_gid_2", {62'd0, grant_id}, 64'd2);

        // Requester 2 cancels in GRANT, then requester 0 is served
        checkOutput("t4_src_grant", {63'd0, trn_tsrc_rdy_n}, 64'd1);
        req_ep = 3'b001;
        tick();
        checkOutput("t4_release", {61'd0, my_trn}, 64'd0);
        checkOutput("t4_err_same", {62'd0, arb_err}, 64'h1);
        checkOutput("t4_src_rel", {63'd0, trn_tsrc_rdy_n}, 64'd1);
        tick();
        tick();
        checkOutput("t4_grant0", {61'd0, my_trn}, 64'h1);
        checkOutput("t4_gid0", {62'd0, grant_id}, 64'd0);
        checkOutput("t4_src_g0", {63'd0, trn_tsrc_rdy_n}, 64'd1);

        // Reset while holding a grant
        rst = 1'b1;
        tick();
        checkOutput("rst_mid_my_trn", {61'd0, my_trn}, 64'd0);
        checkOutput("rst_mid_err", {62'd0, arb_err}, 64'd0);
        rst = 1'b0;

        // Endpoint stall mid-TLP
        tick();
        checkOutput("t5_grant", {61'd0, my_trn}, 64'h1);
        drv_ep = 3'b001;
        tick();
        applyStimulus(0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(0, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b1, 1'b0);
        trn_tdst_rdy_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            checkOutput($sformatf("t5_stall_dst_%0d", c), {61'd0, req_tdst_rdy_n}, 64'h7);
            checkOutput($sformatf("t5_stall_td_%0d", c), trn_td, 64'hFEDC_BA98_7654_3210);
            checkOutput($sformatf("t5_stall_hold_%0d", c), {61'd0, my_trn}, 64'h1);
            tick();
        end
        trn_tdst_rdy_n = 1'b0;
        #1;
        checkOutput("t5_resume_dst", {61'd0, req_tdst_rdy_n}, 64'h6);
        tick();
        applyStimulus(0, 64'h0000_0000_0000_00EE, 1'b1, 1'b0, 1'b0);
        tick();
        idleReq(0);
        drv_ep = 3'b000;
        req_ep = 3'b000;
        tick();
        checkOutput("t5_release", {61'd0, my_trn}, 64'd0);
        checkOutput("t5_clean", {62'd0, arb_err}, 64'd0);
        tick();

        // Grant without drv_ep: watchdog revoke or indefinite hold
        req_ep = 3'b010;
        tick();
        checkOutput("t6_grant", {61'd0, my_trn}, 64'h2);
`ifdef EP_ARB_WDOG_EN
        repeat (15) tick();
        checkOutput("t6_before_revoke", {61'd0, my_trn}, 64'h2);
        tick();
        checkOutput("t6_revoked", {61'd0, my_trn}, 64'd0);
        checkOutput("t6_wdog_err", {62'd0, arb_err}, 64'h2);
`else
        repeat (100) tick();
        checkOutput("t6_held", {61'd0, my_trn}, 64'h2);
        checkOutput("t6_no_err", {62'd0, arb_err}, 64'd0);
`endif
        req_ep = 3'b000;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
